// File: rtl/ps2_digit_scan_ctrl_if.sv
// Byte-input and decoder link for ps2_digit_scan_ctrl.
// master: byte source plus the attached decoder; slave: the scan controller.
interface ps2_digit_scan_ctrl_if;
    logic [7:0] code_in;
    logic       code_valid;
    logic       clear;
    logic [7:0] dec_code;
    logic [6:0] dec_seg;

    modport master (
        output code_in,
        output code_valid,
        output clear,
        input  dec_code,
        output dec_seg
    );

    modport slave (
        input  code_in,
        input  code_valid,
        input  clear,
        output dec_code,
        input  dec_seg
    );
endinterface

// File: rtl/ps2_digit_scan_ctrl.sv
// PS/2 make-code parser, digit buffer and multiplexed 7-segment scan.
// Optional typematic-repeat suppression via `define REPEAT_FILTER_EN.
module ps2_digit_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ps2_digit_scan_ctrl_if.slave  bus,
    output logic [6:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic [7:0]            o_key_count
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_elig;
    logic             w_brk_done;
    logic             w_accept;
    logic [7:0]       r_buf [NUM_DIGITS];
    logic [IDX_W-1:0] r_digit_idx;
    logic [CNT_W-1:0] r_refresh;
    logic [NUM_DIGITS-1:0] w_an;

    // clear suppresses every parser event, so a byte arriving with it is dropped
    always_comb begin
        w_next     = r_state;
        w_elig     = 1'b0;
        w_brk_done = 1'b0;
        if (bus.code_valid && !bus.clear) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.code_in == 8'hE0) begin
                        w_next = EXT;
                    end else if (bus.code_in == 8'hF0) begin
                        w_next = BRK;
                    end else if (bus.code_in != 8'h00 && !bus.code_in[7]) begin
                        w_elig = 1'b1;
                    end
                end
                BRK: begin
                    w_next     = IDLE;
                    w_brk_done = 1'b1;
                end
                EXT: begin
                    w_next = (bus.code_in == 8'hF0) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else if (bus.clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef REPEAT_FILTER_EN
    logic [7:0] r_last_make;
    logic       r_held;

    assign w_accept = w_elig && !(r_held && bus.code_in == r_last_make);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_make <= '0;
            r_held      <= 1'b0;
        end else if (bus.clear) begin
            r_last_make <= '0;
            r_held      <= 1'b0;
        end else if (w_accept) begin
            r_last_make <= bus.code_in;
            r_held      <= 1'b1;
        end else if (w_brk_done && bus.code_in == r_last_make) begin
            r_held      <= 1'b0;
        end
    end
`else
    assign w_accept = w_elig;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) r_buf[i] <= '0;
            o_key_count <= '0;
        end else if (bus.clear) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) r_buf[i] <= '0;
            o_key_count <= '0;
        end else if (w_accept) begin
            for (int unsigned i = 1; i < NUM_DIGITS; i++) r_buf[i] <= r_buf[i-1];
            r_buf[0]    <= bus.code_in;
            o_key_count <= o_key_count + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_refresh   <= '0;
            r_digit_idx <= '0;
        end else if (r_refresh == CNT_W'(REFRESH_DIV - 1)) begin
            r_refresh   <= '0;
            r_digit_idx <= (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                   : r_digit_idx + IDX_W'(1);
        end else begin
            r_refresh   <= r_refresh + CNT_W'(1);
        end
    end

    assign bus.dec_code = r_buf[r_digit_idx];

    always_comb begin
        w_an              = '1;
        w_an[r_digit_idx] = 1'b0;
    end

    // seg and an share one register stage so the pins never show a digit/segment skew
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_seg <= 7'h7F;
            o_an  <= '1;
        end else begin
            o_seg <= bus.dec_seg;
            o_an  <= w_an;
        end
    end
endmodule
